// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the default reset PC.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_ISSUE = 2'd1,
    S_RETRY = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts cycles spent waiting on instruction memory and flags the cycle in
// which the fetch request has waited TIMEOUT_CYC cycles without data.
module fetch_wait_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] wait_cnt;

  assign expired = run && (wait_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (run) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the fetch handshake with
// instruction memory and holds the fetched word until the core retires it.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                WORD_W      = 16,
  parameter logic [WORD_W-1:0] RESET_PC    = WORD_W'(RESET_PC_DEFAULT),
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_read,
  output logic [WORD_W-1:0] i_address,
  input  logic [WORD_W-1:0] i_data,
  input  logic              input_ready,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus1,
  input  logic              instr_accept,
  input  logic [WORD_W-1:0] next_pc,
  input  logic              halt,
  output logic [WORD_W-1:0] num_inst,
  output logic              is_halted,
  output logic              fetch_err,
  output logic [1:0]        state_dbg
);

  // Handshakes:
  //  memory side - mem_read is held high with i_address stable until a
  //    one-cycle input_ready pulse delivers i_data; the request may be
  //    withdrawn (timeout or reset) without an acknowledge.
  //  core side   - instr_valid/instr are held until the core pulses
  //    instr_accept, which also carries next_pc and halt for that edge.

  fetch_state_e state;
  logic         timer_run;
  logic         timer_clear;
  logic         timeout;

  assign i_address = pc;
  assign pc_plus1  = pc + WORD_W'(1);
  assign state_dbg = state;

  // The cycle right after reset release is in S_REQ but not yet requesting,
  // so only cycles with mem_read high count towards the timeout.
  assign timer_run   = (state == S_REQ) && mem_read;
  assign timer_clear = input_ready || timeout;

  fetch_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (timer_run),
    .clear  (timer_clear),
    .expired(timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      num_inst    <= '0;
      fetch_err   <= 1'b0;
      is_halted   <= 1'b0;
      mem_read    <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          // Data arriving in the timeout cycle still completes the fetch.
          if (input_ready) begin
            instr       <= i_data;
            instr_valid <= 1'b1;
            mem_read    <= 1'b0;
            state       <= S_ISSUE;
          end else if (timeout) begin
            fetch_err <= 1'b1;
            mem_read  <= 1'b0;
            state     <= S_RETRY;
          end else begin
            mem_read <= 1'b1;
          end
        end
        S_RETRY: begin
          mem_read <= 1'b1;
          state    <= S_REQ;
        end
        S_ISSUE: begin
          if (instr_accept) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            num_inst    <= num_inst + WORD_W'(1);
            if (halt) begin
              is_halted <= 1'b1;
              mem_read  <= 1'b0;
              state     <= S_HALT;
            end else begin
              mem_read <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        S_HALT: begin
          mem_read    <= 1'b0;
          instr_valid <= 1'b0;
          is_halted   <= 1'b1;
        end
        default: begin
          mem_read <= 1'b1;
          state    <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized checks of instr_fetch_unit against a
// transaction-level reference model of PC, retire count and error flag.
module tb_instr_fetch_unit;

  localparam int          W        = 16;
  localparam int          TO       = 4;
  localparam logic [15:0] RST_PC   = 16'h0000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_read;
  logic [W-1:0]  i_address;
  logic [W-1:0]  i_data;
  logic          input_ready;
  logic [W-1:0]  instr;
  logic          instr_valid;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc_plus1;
  logic          instr_accept;
  logic [W-1:0]  next_pc;
  logic          halt;
  logic [W-1:0]  num_inst;
  logic          is_halted;
  logic          fetch_err;
  logic [1:0]    state_dbg;

  int tests  = 0;
  int failed = 0;

  // reference model
  logic [W-1:0] m_pc;
  logic [W-1:0] m_num;
  logic [W-1:0] m_instr;
  logic         m_err;

  instr_fetch_unit #(
    .WORD_W     (W),
    .RESET_PC   (RST_PC),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_read    (mem_read),
    .i_address   (i_address),
    .i_data      (i_data),
    .input_ready (input_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .instr_accept(instr_accept),
    .next_pc     (next_pc),
    .halt        (halt),
    .num_inst    (num_inst),
    .is_halted   (is_halted),
    .fetch_err   (fetch_err),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_num   = '0;
    m_instr = '0;
    m_err   = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (mem_read !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("req_seen", {15'd0, mem_read}, 16'd1);
  endtask

  // Memory answers after `delay` requesting cycles (delay < TO is in time).
  task automatic serve(input logic [W-1:0] data, input int delay);
    wait_req();
    check("req_addr", i_address, m_pc);
    for (int d = 0; d < delay; d++) begin
      i_data = W'($urandom);
      tick();
      check("req_hold", {15'd0, mem_read}, 16'd1);
      check("req_addr_hold", i_address, m_pc);
    end
    i_data      = data;
    input_ready = 1'b1;
    tick();
    input_ready = 1'b0;
    i_data      = W'($urandom);
    m_instr     = data;
    check("fetch_valid", {15'd0, instr_valid}, 16'd1);
    check("fetch_instr", instr, m_instr);
    check("fetch_mem_read_low", {15'd0, mem_read}, 16'd0);
    check("fetch_err_kept", {15'd0, fetch_err}, {15'd0, m_err});
  endtask

  // Let the request expire: TO cycles high, one low, then high again.
  task automatic do_timeout(input logic pulse_in_retry);
    wait_req();
    for (int i = 0; i < TO; i++) begin
      check("to_req_high", {15'd0, mem_read}, 16'd1);
      tick();
    end
    m_err = 1'b1;
    check("to_retry_low", {15'd0, mem_read}, 16'd0);
    check("to_err_set", {15'd0, fetch_err}, 16'd1);
    if (pulse_in_retry) begin
      i_data      = ~m_instr;
      input_ready = 1'b1;
    end
    tick();
    input_ready = 1'b0;
    check("to_rereq", {15'd0, mem_read}, 16'd1);
    check("to_same_addr", i_address, m_pc);
    check("to_no_valid", {15'd0, instr_valid}, 16'd0);
    check("to_instr_kept", instr, m_instr);
  endtask

  task automatic accept(input logic [W-1:0] npc, input logic h, input int hold);
    for (int i = 0; i < hold; i++) begin
      input_ready = 1'($urandom_range(0, 1));
      i_data      = W'($urandom);
      tick();
      input_ready = 1'b0;
      check("issue_hold_valid", {15'd0, instr_valid}, 16'd1);
      check("issue_hold_instr", instr, m_instr);
      check("issue_hold_pc", pc, m_pc);
    end
    instr_accept = 1'b1;
    next_pc      = npc;
    halt         = h;
    tick();
    instr_accept = 1'b0;
    halt         = 1'b0;
    next_pc      = W'($urandom);
    m_pc  = npc;
    m_num = m_num + 16'd1;
    check("acc_pc", pc, m_pc);
    check("acc_pc_plus1", pc_plus1, m_pc + 16'd1);
    check("acc_num", num_inst, m_num);
    check("acc_valid_low", {15'd0, instr_valid}, 16'd0);
    check("acc_halted", {15'd0, is_halted}, {15'd0, h});
    check("acc_mem_read", {15'd0, mem_read}, {15'd0, ~h});
  endtask

  initial begin
    logic [W-1:0] npc;
    reset_n      = 1'b0;
    i_data       = '0;
    input_ready  = 1'b0;
    instr_accept = 1'b0;
    next_pc      = '0;
    halt         = 1'b0;
    model_reset();

    // reset state
    repeat (3) tick();
    check("rst_mem_read", {15'd0, mem_read}, 16'd0);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, 16'h0000);
    check("rst_num", num_inst, 16'h0000);
    check("rst_err", {15'd0, fetch_err}, 16'd0);
    check("rst_halted", {15'd0, is_halted}, 16'd0);
    check("rst_state", {14'd0, state_dbg}, 16'd0);
    reset_n = 1'b1;
    tick();
    check("first_req", {15'd0, mem_read}, 16'd1);
    check("first_addr", i_address, 16'h0000);

    // first fetch, then sequential and jump accepts
    serve(16'h4A05, 0);
    accept(16'h0001, 1'b0, 1);
    serve(W'($urandom), 1);
    accept(16'h0010, 1'b0, 0);

    // timeout with input_ready in retry, then a good fetch keeps fetch_err
    do_timeout(1'b1);
    serve(16'hBEEF, 2);
    i_data      = 16'h1234;
    input_ready = 1'b1;
    tick();
    input_ready = 1'b0;
    check("issue_ignore_instr", instr, 16'hBEEF);
    check("issue_ignore_state", {14'd0, state_dbg}, 16'd1);
    check("issue_ignore_valid", {15'd0, instr_valid}, 16'd1);
    accept(16'h0010, 1'b0, 0);

    // data arriving in the timeout cycle wins without raising the flag
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    model_reset();
    tick();
    serve(16'h7777, TO - 1);
    check("boundary_no_err", {15'd0, fetch_err}, 16'd0);
    accept(16'h0002, 1'b0, 0);

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 4) == 0) do_timeout(1'($urandom_range(0, 1)));
      serve(W'($urandom), $urandom_range(0, TO - 1));
      case ($urandom_range(0, 3))
        0:       npc = m_pc;
        1:       npc = m_pc + 16'd1;
        2:       npc = 16'hFFFF;
        default: npc = W'($urandom);
      endcase
      accept(npc, 1'b0, $urandom_range(0, 3));
    end

    // pc wrap
    serve(W'($urandom), 0);
    accept(16'hFFFF, 1'b0, 0);
    check("wrap_plus1", pc_plus1, 16'h0000);
    serve(W'($urandom), 1);
    accept(pc_plus1, 1'b0, 0);
    check("wrap_pc", pc, 16'h0000);

    // async reset mid-request
    wait_req();
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_mem_read", {15'd0, mem_read}, 16'd0);
    check("async_rst_pc", pc, RST_PC);
    #1;
    reset_n = 1'b1;
    model_reset();
    tick();
    check("rerelease_req", {15'd0, mem_read}, 16'd1);
    serve(16'h0F0F, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", {15'd0, instr_valid}, 16'd0);
    check("async_rst_instr", instr, 16'h0000);
    #1;
    reset_n = 1'b1;
    tick();

    // halt: everything frozen for 20 cycles despite stray inputs
    serve(16'hF000, 1);
    accept(16'h0033, 1'b1, 1);
    for (int i = 0; i < 20; i++) begin
      input_ready  = 1'($urandom_range(0, 1));
      instr_accept = 1'($urandom_range(0, 1));
      next_pc      = W'($urandom);
      halt         = 1'($urandom_range(0, 1));
      tick();
      check("halt_mem_read", {15'd0, mem_read}, 16'd0);
      check("halt_flag", {15'd0, is_halted}, 16'd1);
    end
    input_ready  = 1'b0;
    instr_accept = 1'b0;
    halt         = 1'b0;
    check("halt_num", num_inst, m_num);
    check("halt_pc", pc, m_pc);
    check("halt_instr", instr, m_instr);
    check("halt_valid", {15'd0, instr_valid}, 16'd0);

    // reset pulse leaves halt and fetching resumes from RESET_PC
    reset_n = 1'b0;
    #1;
    check("unhalt_pc", pc, RST_PC);
    check("unhalt_num", num_inst, 16'h0000);
    check("unhalt_flag", {15'd0, is_halted}, 16'd0);
    reset_n = 1'b1;
    model_reset();
    tick();
    serve(16'h4A05, 0);
    accept(16'h0001, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    failed++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction interface: fetches 16-bit instruction words from instruction memory and presents them, held stable, to the combinational control unit and datapath.
- Owns the PC register and the fetch handshake to memory.
- Receives the next PC and a halt indication from the core when the current instruction retires.
- Counts retired instructions.

Parameters:
- WORD_W, 16, instruction/address/PC width.
- RESET_PC, 16'h0000, PC value loaded at reset.
- TIMEOUT_CYC, 255, cycles spent in S_REQ without input_ready before a retry (minimum 2).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  out  1  instruction memory read request.
- i_address  out  WORD_W  fetch address; equals pc while mem_read=1.
- i_data  in  WORD_W  instruction word from memory; valid when input_ready=1.
- input_ready  in  1  memory data-valid pulse.
- instr  out  WORD_W  current instruction to control unit/datapath.
- instr_valid  out  1  instr holds a fetched, unretired instruction.
- pc  out  WORD_W  address of the current instruction.
- pc_plus1  out  WORD_W  pc+1 mod 2^WORD_W, used as the JAL/JRL link value.
- instr_accept  in  1  core retires the current instruction this cycle.
- next_pc  in  WORD_W  PC of the next instruction; sampled with instr_accept.
- halt  in  1  current instruction is HLT; sampled with instr_accept.
- num_inst  out  WORD_W  retired-instruction count.
- is_halted  out  1  fetch permanently stopped.
- fetch_err  out  1  sticky flag: at least one fetch timeout occurred.

Behaviour:
- Reset (asynchronous, reset_n=0) drives:
  - state=S_REQ, pc=RESET_PC, instr=0, instr_valid=0, num_inst=0, fetch_err=0, is_halted=0, wait_cnt=0.
  - mem_read=0 while reset_n=0. mem_read goes to 1 in the first cycle after release.
- Reset mid-fetch abandons the request. Memory must tolerate mem_read dropping without an acknowledge.
- All outputs are registered, except i_address (=pc) and pc_plus1 (=pc+1), which are combinational from pc.
- S_REQ:
  - mem_read=1; i_address=pc held stable.
  - wait_cnt increments each cycle.
  - input_ready=1 at an edge: instr<=i_data, instr_valid<=1, wait_cnt<=0, go to S_ISSUE. mem_read=0 from the next cycle.
  - Latency: input_ready in cycle N gives instr_valid=1 in cycle N+1. Minimum 2 cycles from request to instr_valid.
  - wait_cnt reaches TIMEOUT_CYC-1 with input_ready=0: fetch_err<=1, wait_cnt<=0, go to S_RETRY.
  - input_ready and timeout in the same cycle: the data wins, fetch_err is unchanged.
- S_RETRY:
  - One cycle with mem_read=0, then return to S_REQ with the same pc.
  - input_ready is ignored.
- S_ISSUE:
  - instr, pc and instr_valid=1 are held until instr_accept=1.
  - On the accepting edge: pc<=next_pc, instr_valid<=0, num_inst<=num_inst+1 (wraps at 2^WORD_W).
  - Then, if halt=1, go to S_HALT. Otherwise go to S_REQ, and mem_read=1 in the next cycle.
  - input_ready is ignored.
- S_HALT:
  - mem_read=0, instr_valid=0, is_halted=1.
  - pc, num_inst and instr are frozen. Only reset exits.
- instr_accept outside S_ISSUE is ignored. next_pc and halt are don't-care when instr_accept=0.
- next_pc may be any value, including pc, which re-fetches the same address. pc arithmetic wraps modulo 2^WORD_W, so pc=16'hFFFF gives pc_plus1=16'h0000.
- State encoding: 2-bit, S_REQ=0, S_ISSUE=1, S_RETRY=2, S_HALT=3. No illegal states; the default branch returns to S_REQ.

Decomposition:
- Shared include fetch_defs.v, next to opcodes.v: state encodings S_REQ, S_ISSUE, S_RETRY and S_HALT, plus the RESET_PC default.
- One sub-module, fetch_wait_timer:
  - Holds wait_cnt with width clog2(TIMEOUT_CYC).
  - Inputs: clk, reset_n, run (=S_REQ), clear (=input_ready or timeout).
  - Output: expired.
- The FSM, PC register, instr latch and counters stay in instr_fetch_unit.

Test Plan:
- Reset release, memory answers input_ready 1 cycle after mem_read rises, i_data=16'h4A05 -> mem_read=1 with i_address=16'h0000 first; instr=16'h4A05 and instr_valid=1 one cycle after input_ready; mem_read=0.
- Accept with next_pc=16'h0001, then next_pc=16'h0010 (jump) -> i_address=16'h0001, then 16'h0010; num_inst=1, then 2; pc_plus1 tracks pc+1.
- Memory never responds, TIMEOUT_CYC=4 -> mem_read high 4 cycles, low 1 cycle, high again at the same address; fetch_err=1 and stays 1 after a later successful fetch.
- input_ready pulsed during S_ISSUE and during S_RETRY -> instr unchanged, no state change.
- Accept with halt=1 -> is_halted=1 next cycle, mem_read stays 0 for 20 cycles, num_inst frozen; reset_n pulse -> pc=RESET_PC, num_inst=0, fetching resumes.
- reset_n asserted while mem_read=1 in S_REQ -> mem_read=0 and instr_valid=0 immediately (asynchronous, not waiting for clk); next_pc=16'hFFFF accept -> pc_plus1=16'h0000.
